// File: rtl/mem_arb_pkg.sv
// Shared memory-bus encodings and tag width for the memory arbiter.
package mem_arb_pkg;
  localparam int         MEM_TAG_W = 4;
  localparam logic [1:0] BUS_NONE  = 2'b00;
  localparam logic [1:0] BUS_LOAD  = 2'b01;
  localparam logic [1:0] BUS_STORE = 2'b10;
endpackage

// File: rtl/mem_arb_tag_table.sv
// Tag ownership table: which requester owns each outstanding memory tag,
// plus the count of accepted, unreturned loads.
module mem_tag_table #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en_i,
  input  logic [TAG_W-1:0] set_tag_i,
  input  logic             set_id_i,
  input  logic [TAG_W-1:0] lkp_tag_i,
  output logic             lkp_hit_o,
  output logic             lkp_id_o,
  output logic             lkp_miss_o,
  output logic             set_dup_o,
  output logic [TAG_W:0]   outstanding_o
);
  localparam int             DEPTH   = 1 << TAG_W;
  localparam logic [TAG_W:0] CNT_MAX = (TAG_W+1)'(DEPTH - 1);

  logic [DEPTH-1:0] vld_q, vld_d, own_q, own_d;
  logic [TAG_W:0]   cnt_q, cnt_d;
  logic             lkp_act;

  assign lkp_act    = lkp_tag_i != '0;
  assign lkp_hit_o  = lkp_act && vld_q[lkp_tag_i];
  assign lkp_miss_o = lkp_act && !vld_q[lkp_tag_i];
  assign lkp_id_o   = own_q[lkp_tag_i];
  // A same-tag return this cycle frees the entry, so reuse is legal then.
  assign set_dup_o  = set_en_i && vld_q[set_tag_i] && !(lkp_act && lkp_tag_i == set_tag_i);

  always_comb begin
    vld_d = vld_q;
    own_d = own_q;
    cnt_d = cnt_q;
    if (lkp_hit_o) vld_d[lkp_tag_i] = 1'b0;
    if (set_en_i) begin
      vld_d[set_tag_i] = 1'b1;
      own_d[set_tag_i] = set_id_i;
    end
    if (set_en_i && !lkp_hit_o && cnt_q != CNT_MAX)      cnt_d = cnt_q + 1'b1;
    else if (lkp_hit_o && !set_en_i && cnt_q != '0)      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
    end
  end

  assign outstanding_o = cnt_q;
endmodule

// File: rtl/mem_arb.sv
// Two-port round-robin arbiter for the shared memory port, with grant lock
// until accept and tag-based routing of load returns.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int TAG_W  = MEM_TAG_W,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0][1:0]        req_cmd_i,
  input  logic [1:0][ADDR_W-1:0] req_addr_i,
  input  logic [1:0][DATA_W-1:0] req_data_i,
  output logic [1:0][TAG_W-1:0]  req_rsp_o,
  output logic [1:0][TAG_W-1:0]  req_tag_o,
  output logic [DATA_W-1:0]      req_data_o,
  output logic [1:0]             proc2mem_command_o,
  output logic [ADDR_W-1:0]      proc2mem_addr_o,
  output logic [DATA_W-1:0]      proc2mem_data_o,
  input  logic [TAG_W-1:0]       mem2proc_response_i,
  input  logic [TAG_W-1:0]       mem2proc_tag_i,
  input  logic [DATA_W-1:0]      mem2proc_data_i,
  output logic [TAG_W:0]         outstanding_o,
  output logic                   err_o
);
  logic [1:0]       req;
  logic             any_req, lock_act, gnt, accept, load_acc;
  logic             lock_q, lock_d, lock_id_q, lock_id_d, last_q, last_d, err_q, err_d;
  logic [TAG_W-1:0] ret_tag;
  logic             hit, hit_id, miss, dup;

  assign req[0]  = req_cmd_i[0] != BUS_NONE;
  assign req[1]  = req_cmd_i[1] != BUS_NONE;
  assign any_req = (|req) && !rst;

  // A lock only holds while its owner keeps requesting.
  always_comb begin
    lock_act = lock_q && req[lock_id_q];
    gnt      = req[1];
    if (lock_act)          gnt = lock_id_q;
    else if (req == 2'b11) gnt = ~last_q;
  end

  assign accept   = any_req && mem2proc_response_i != '0;
  assign load_acc = accept && req_cmd_i[gnt] == BUS_LOAD;
  assign ret_tag  = rst ? '0 : mem2proc_tag_i;

  mem_tag_table #(.TAG_W(TAG_W)) u_tags (
    .clk           (clk),
    .rst           (rst),
    .set_en_i      (load_acc),
    .set_tag_i     (mem2proc_response_i),
    .set_id_i      (gnt),
    .lkp_tag_i     (ret_tag),
    .lkp_hit_o     (hit),
    .lkp_id_o      (hit_id),
    .lkp_miss_o    (miss),
    .set_dup_o     (dup),
    .outstanding_o (outstanding_o)
  );

  always_comb begin
    proc2mem_command_o = BUS_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    req_rsp_o          = '0;
    req_tag_o          = '0;
    req_data_o         = '0;
    if (any_req) begin
      proc2mem_command_o = req_cmd_i[gnt];
      proc2mem_addr_o    = req_addr_i[gnt];
      proc2mem_data_o    = gnt ? req_data_i[gnt] : '0;
      req_rsp_o[gnt]     = mem2proc_response_i;
    end
    if (hit) begin
      req_tag_o[hit_id] = ret_tag;
      req_data_o        = mem2proc_data_i;
    end
  end

  always_comb begin
    lock_d    = 1'b0;
    lock_id_d = lock_id_q;
    last_d    = last_q;
    if (accept) begin
      last_d = gnt;
    end else if (any_req) begin
      lock_d    = 1'b1;
      lock_id_d = gnt;
    end
    err_d = err_q | miss | dup;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a per-cycle reference model of arbitration,
// tag ownership, outstanding count and error flag.
module tb_mem_arb;
  import mem_arb_pkg::*;
  localparam int TAG_W  = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [1:0][1:0]        req_cmd   = '0;
  logic [1:0][ADDR_W-1:0] req_addr  = '0;
  logic [1:0][DATA_W-1:0] req_wdata = '0;
  logic [1:0][TAG_W-1:0]  req_rsp, req_tag;
  logic [DATA_W-1:0]      req_rdata;
  logic [1:0]             p2m_cmd;
  logic [ADDR_W-1:0]      p2m_addr;
  logic [DATA_W-1:0]      p2m_data;
  logic [TAG_W-1:0]       m_resp = '0;
  logic [TAG_W-1:0]       m_tag  = '0;
  logic [DATA_W-1:0]      m_data = '0;
  logic [TAG_W:0]         outstanding;
  logic                   err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arb #(.TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_cmd_i           (req_cmd),
    .req_addr_i          (req_addr),
    .req_data_i          (req_wdata),
    .req_rsp_o           (req_rsp),
    .req_tag_o           (req_tag),
    .req_data_o          (req_rdata),
    .proc2mem_command_o  (p2m_cmd),
    .proc2mem_addr_o     (p2m_addr),
    .proc2mem_data_o     (p2m_data),
    .mem2proc_response_i (m_resp),
    .mem2proc_tag_i      (m_tag),
    .mem2proc_data_i     (m_data),
    .outstanding_o       (outstanding),
    .err_o               (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: tag ownership, load count, sticky error, fairness/lock.
  bit mv[16];
  bit mo[16];
  int mcnt  = 0;
  bit merr  = 0;
  bit mlast = 1;
  bit mlock = 0;
  bit mlock_id = 0;

  always @(negedge clk) begin
    bit r0, r1, any, g, acc, ret, hit, ld;
    logic [1:0]             e_cmd;
    logic [ADDR_W-1:0]      e_addr;
    logic [DATA_W-1:0]      e_wd, e_rd;
    logic [1:0][TAG_W-1:0]  e_rsp, e_tag;
    if (rst) begin
      check("rst_cmd",   64'(p2m_cmd), 64'(BUS_NONE));
      check("rst_addr",  64'(p2m_addr), 64'd0);
      check("rst_wdata", 64'(p2m_data), 64'd0);
      check("rst_rsp",   64'(req_rsp), 64'd0);
      check("rst_tag",   64'(req_tag), 64'd0);
      check("rst_rdata", 64'(req_rdata), 64'd0);
      check("rst_cnt",   64'(outstanding), 64'd0);
      check("rst_err",   64'(err), 64'd0);
      foreach (mv[i]) mv[i] = 1'b0;
      mcnt = 0; merr = 0; mlast = 1; mlock = 0; mlock_id = 0;
    end else begin
      r0  = req_cmd[0] != BUS_NONE;
      r1  = req_cmd[1] != BUS_NONE;
      any = r0 || r1;
      if (mlock && (mlock_id ? r1 : r0)) g = mlock_id;
      else if (r0 && r1)                 g = ~mlast;
      else                               g = r1;
      e_cmd  = any ? req_cmd[g] : BUS_NONE;
      e_addr = any ? req_addr[g] : '0;
      e_wd   = (any && g) ? req_wdata[1] : '0;
      e_rsp  = '0;
      if (any) e_rsp[g] = m_resp;
      ret = m_tag != '0;
      hit = ret && mv[m_tag];
      e_tag = '0;
      e_rd  = '0;
      if (hit) begin
        e_tag[mo[m_tag]] = m_tag;
        e_rd = m_data;
      end
      check("cmd",   64'(p2m_cmd), 64'(e_cmd));
      check("addr",  64'(p2m_addr), 64'(e_addr));
      check("wdata", 64'(p2m_data), 64'(e_wd));
      check("rsp",   64'(req_rsp), 64'(e_rsp));
      check("tag",   64'(req_tag), 64'(e_tag));
      check("rdata", 64'(req_rdata), 64'(e_rd));
      check("cnt",   64'(outstanding), 64'(mcnt));
      check("err",   64'(err), 64'(merr));
      acc = any && m_resp != '0;
      ld  = acc && req_cmd[g] == BUS_LOAD;
      if (ret && !hit) merr = 1;
      if (ld && mv[m_resp] && !(ret && m_tag == m_resp)) merr = 1;
      if (hit) mv[m_tag] = 1'b0;
      if (ld) begin
        mv[m_resp] = 1'b1;
        mo[m_resp] = g;
      end
      mcnt = mcnt + int'(ld) - int'(hit);
      if (mcnt > 15) mcnt = 15;
      if (mcnt < 0)  mcnt = 0;
      if (acc) begin
        mlock = 0;
        mlast = g;
      end else if (any) begin
        mlock = 1;
        mlock_id = g;
      end else begin
        mlock = 0;
      end
    end
  end

  task automatic drive(input logic [1:0] c0, input logic [63:0] a0,
                       input logic [1:0] c1, input logic [63:0] a1, input logic [63:0] d1,
                       input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] rd);
    req_cmd[0]   = c0;
    req_addr[0]  = a0;
    req_wdata[0] = 64'hBAD0_BAD0;
    req_cmd[1]   = c1;
    req_addr[1]  = a1;
    req_wdata[1] = d1;
    m_resp       = resp;
    m_tag        = tag;
    m_data       = rd;
  endtask

  task automatic idle();
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("por_cnt", 64'(outstanding), 64'd0);
    check("por_err", 64'(err), 64'd0);
    check("por_cmd", 64'(p2m_cmd), 64'(BUS_NONE));
    rst = 1'b0;

    // single port-0 load, return 5 cycles later
    tick();
    drive(BUS_LOAD, 'h100, BUS_NONE, 0, 0, 3, 0, 0);
    #1;
    check("t1_rsp0", 64'(req_rsp[0]), 64'd3);
    check("t1_rsp1", 64'(req_rsp[1]), 64'd0);
    check("t1_addr", 64'(p2m_addr), 64'h100);
    tick();
    idle();
    check("t1_cnt1", 64'(outstanding), 64'd1);
    repeat (4) tick();
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 3, 'hDEAD);
    #1;
    check("t1_tag0", 64'(req_tag[0]), 64'd3);
    check("t1_tag1", 64'(req_tag[1]), 64'd0);
    check("t1_data", 64'(req_rdata), 64'hDEAD);
    tick();
    idle();
    check("t1_cnt0", 64'(outstanding), 64'd0);

    // both ports load continuously: grants alternate from port 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(BUS_LOAD, 'h200, BUS_LOAD, 'h300, 0, 4'(i + 1), 0, 0);
      #1;
      check("t2_grant", 64'(p2m_addr), (i % 2 == 0) ? 64'h200 : 64'h300);
      tick();
    end
    idle();
    check("t2_peak", 64'(outstanding), 64'd4);
    for (int i = 0; i < 4; i++) begin
      drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 4'(i + 1), 64'hA0 + 64'(i));
      #1;
      check("t2_route",  64'(req_tag[i % 2]), 64'(i + 1));
      check("t2_other",  64'(req_tag[1 - (i % 2)]), 64'd0);
      tick();
    end
    idle();
    check("t2_cnt0", 64'(outstanding), 64'd0);

    // port-1 store held under lock while port 0 waits
    drive(BUS_NONE, 0, BUS_STORE, 'h400, 'h55, 0, 0, 0);
    #1;
    check("t3_lock_a", 64'(p2m_addr), 64'h400);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(BUS_LOAD, 'h500, BUS_STORE, 'h400, 'h55, 0, 0, 0);
      #1;
      check("t3_lock_b", 64'(p2m_addr), 64'h400);
      check("t3_rsp0",   64'(req_rsp[0]), 64'd0);
      tick();
    end
    drive(BUS_LOAD, 'h500, BUS_STORE, 'h400, 'h55, 6, 0, 0);
    #1;
    check("t3_acc_rsp",  64'(req_rsp[1]), 64'd6);
    check("t3_acc_cmd",  64'(p2m_cmd), 64'(BUS_STORE));
    check("t3_acc_data", 64'(p2m_data), 64'h55);
    tick();
    drive(BUS_LOAD, 'h500, BUS_NONE, 0, 0, 7, 0, 0);
    #1;
    check("t3_next_addr", 64'(p2m_addr), 64'h500);
    check("t3_next_rsp",  64'(req_rsp[0]), 64'd7);
    tick();
    // locked port drops; other port served in the same cycle
    drive(BUS_LOAD, 'h510, BUS_NONE, 0, 0, 0, 0, 0);
    tick();
    drive(BUS_NONE, 0, BUS_LOAD, 'h520, 0, 8, 0, 0);
    #1;
    check("t3_drop_addr", 64'(p2m_addr), 64'h520);
    check("t3_drop_rsp",  64'(req_rsp[1]), 64'd8);
    tick();
    idle();
    check("t3_cnt2", 64'(outstanding), 64'd2);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 7, 'h77);
    #1;
    check("t3_ret7", 64'(req_tag[0]), 64'd7);
    tick();
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 8, 'h88);
    #1;
    check("t3_ret8", 64'(req_tag[1]), 64'd8);
    tick();
    idle();

    // same-cycle return and re-accept of tag 5
    drive(BUS_LOAD, 'h600, BUS_NONE, 0, 0, 5, 0, 0);
    tick();
    drive(BUS_NONE, 0, BUS_LOAD, 'h700, 0, 5, 5, 'hBEEF);
    #1;
    check("t4_old_owner", 64'(req_tag[0]), 64'd5);
    check("t4_new_quiet", 64'(req_tag[1]), 64'd0);
    check("t4_data",      64'(req_rdata), 64'hBEEF);
    tick();
    idle();
    check("t4_cnt", 64'(outstanding), 64'd1);
    check("t4_err", 64'(err), 64'd0);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 5, 'h5);
    #1;
    check("t4_new_owner", 64'(req_tag[1]), 64'd5);
    tick();
    idle();

    // stray return of tag 9
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 9, 'h9);
    #1;
    check("t5_drop", 64'(req_tag), 64'd0);
    tick();
    idle();
    check("t5_err", 64'(err), 64'd1);
    tick();
    check("t5_sticky", 64'(err), 64'd1);

    // reset with loads outstanding, then a stale return
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(BUS_LOAD, 64'h800 + 64'(i), BUS_NONE, 0, 0, 4'(i), 0, 0);
      tick();
    end
    drive(BUS_LOAD, 'h900, BUS_NONE, 0, 0, 0, 0, 0);
    check("t6_cnt3", 64'(outstanding), 64'd3);
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_cnt", 64'(outstanding), 64'd0);
    check("t6_rst_cmd", 64'(p2m_cmd), 64'(BUS_NONE));
    drive(BUS_LOAD, 'h900, BUS_NONE, 0, 0, 0, 1, 'h1);
    #1;
    check("t6_rst_tag", 64'(req_tag), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    idle();
    tick();
    check("t6_no_err", 64'(err), 64'd0);
    drive(BUS_NONE, 0, BUS_NONE, 0, 0, 0, 2, 'h2);
    #1;
    check("t6_stale_tag", 64'(req_tag), 64'd0);
    tick();
    idle();
    check("t6_stale_err", 64'(err), 64'd1);

    // fill every tag, then overwrite one: counter saturates, error flagged
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      drive(BUS_LOAD, 64'hA00 + 64'(i), BUS_NONE, 0, 0, 4'(i), 0, 0);
      tick();
    end
    check("t7_full", 64'(outstanding), 64'd15);
    drive(BUS_LOAD, 'hB00, BUS_NONE, 0, 0, 1, 0, 0);
    tick();
    idle();
    check("t7_sat", 64'(outstanding), 64'd15);
    check("t7_err", 64'(err), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
